// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the memory port arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DM_B2 = 1'b1;

    // Owner of the read beat issued in the previous cycle.
    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_IF    = 2'd1,
        TAG_DM_B0 = 2'd2,
        TAG_DM_B1 = 2'd3
    } owner_tag_e;

    // Wide enough for STARVE_MAX up to 15.
    localparam int STARVE_CW = 4;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// ============================================================================
//  Module      : arb_starve_ctr
//  Description : Saturating wait counter with clear; flags starvation.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_starved
);

    localparam logic [STARVE_CW-1:0] c_max_cnt = STARVE_MAX[STARVE_CW-1:0];

    logic [STARVE_CW-1:0] cnt_q;
    logic [STARVE_CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != c_max_cnt)) begin
            cnt_d = cnt_q + STARVE_CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_starved = (cnt_q >= c_max_cnt);

endmodule : arb_starve_ctr

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Single-port memory sequencer/arbiter for fetch and data
//                access, with locked two-beat LDW/SDW bursts.
//                Optional macro MEM_ARB_ALIGN_CHECK_EN: odd-address doubles
//                raise dm_excp instead of accessing memory.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic              dm_dbl,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_wdata2,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic              dm_beat,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_excp,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [0:0]  state_q, state_d;
    owner_tag_e  tag_q, tag_d;
    logic        done_q, done_d;
    logic        w_starved;
    logic        w_misalign;
    logic        w_excp;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign w_misalign = dm_dbl & dm_addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (if_req & ~if_gnt),
        .i_clr     (~if_req | if_gnt),
        .o_starved (w_starved)
    );

    // Outputs are held low while reset is asserted, even with requests present.
    always_comb begin
        state_d   = state_q;
        tag_d     = TAG_NONE;
        done_d    = 1'b0;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        w_excp    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (dm_req && (!if_req || !w_starved)) begin
                        dm_gnt = 1'b1;
                        if (w_misalign) begin
                            w_excp = 1'b1;
                        end else begin
                            mem_en    = 1'b1;
                            mem_we    = dm_we;
                            mem_addr  = dm_addr;
                            mem_wdata = dm_we ? dm_wdata : '0;
                            tag_d     = dm_we ? TAG_NONE : TAG_DM_B0;
                            if (dm_dbl) begin
                                state_d = ST_DM_B2;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    end else if (if_req) begin
                        if_gnt   = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = if_addr;
                        tag_d    = TAG_IF;
                    end
                end
                ST_DM_B2: begin
                    mem_en    = 1'b1;
                    mem_we    = dm_we;
                    mem_addr  = dm_addr + ADDR_W'(1);
                    mem_wdata = dm_we ? dm_wdata2 : '0;
                    tag_d     = dm_we ? TAG_NONE : TAG_DM_B1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tag_q   <= TAG_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            done_q  <= done_d;
        end
    end

    assign if_rvalid = (tag_q == TAG_IF);
    assign dm_rvalid = (tag_q == TAG_DM_B0) || (tag_q == TAG_DM_B1);
    assign dm_beat   = (tag_q == TAG_DM_B1);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
    assign dm_done   = done_q | w_excp;
    assign dm_excp   = w_excp;

endmodule : mem_port_arbiter

`default_nettype wire
